// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: run controller for a prescaled up-counter.
// Sequences the counter through start, stop, pause/resume, load and
// terminal-count handling, with a valid/ready command port and status outputs.
module counter_run_ctrl #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [WIDTH-1:0]      cmd_data,
   input  logic [WIDTH-1:0]      limit,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  wrap_en,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  paused,
   output logic                  done,
   output logic                  wrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_START        = 2'b00,
      OP_STOP         = 2'b01,
      OP_PAUSE_TOGGLE = 2'b10,
      OP_LOAD         = 2'b11
   } op_t;

   state_t                state, state_n;
   logic [WIDTH-1:0]      count_n;
   logic [PRESCALE_W-1:0] presc, presc_n;
   logic [WIDTH-1:0]      limit_q, limit_n;
   logic [PRESCALE_W-1:0] prescale_q, prescale_n;
   logic                  wrap_q, wrap_q_n;
   logic                  wrap_n;
   logic                  accept;
   logic                  tick;

   // Status outputs decode the state register only, so nothing combinational
   // reaches cmd_ready from the command inputs.
   always_comb begin
      cmd_ready = (state != DONE);
      busy      = (state == RUN) || (state == PAUSE);
      paused    = (state == PAUSE);
      done      = (state == DONE);
   end

   // Next-state, counter and prescaler update; an accepted command suppresses
   // any tick falling in the same cycle.
   always_comb begin
      state_n    = state;
      count_n    = count;
      presc_n    = presc;
      limit_n    = limit_q;
      prescale_n = prescale_q;
      wrap_q_n   = wrap_q;
      wrap_n     = 1'b0;

      accept = cmd_valid && cmd_ready;
      tick   = (state == RUN) && (presc == prescale_q);

      if (accept) begin
         case (op_t'(cmd_op))
            OP_START: begin
               count_n    = '0;
               presc_n    = '0;
               limit_n    = limit;
               prescale_n = prescale;
               wrap_q_n   = wrap_en;
               state_n    = RUN;
            end
            OP_STOP: begin
               state_n = IDLE;
            end
            OP_PAUSE_TOGGLE: begin
               if (state == RUN)
                  state_n = PAUSE;
               else if (state == PAUSE)
                  state_n = RUN;
            end
            OP_LOAD: begin
               count_n = cmd_data;
               presc_n = '0;
            end
            default: ;
         endcase
      end else begin
         case (state)
            RUN: begin
               if (tick) begin
                  presc_n = '0;
                  if (count == limit_q) begin
                     if (wrap_q) begin
                        count_n = '0;
                        wrap_n  = 1'b1;
                     end else begin
                        state_n = DONE;
                     end
                  end else begin
                     count_n = count + WIDTH'(1);
                  end
               end else begin
                  presc_n = presc + PRESCALE_W'(1);
               end
            end
            DONE:    state_n = IDLE;
            default: ;
         endcase
      end
   end

   // State, counter and latched run settings; reset overrides any command.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         presc      <= '0;
         limit_q    <= '0;
         prescale_q <= '0;
         wrap_q     <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         presc      <= presc_n;
         limit_q    <= limit_n;
         prescale_q <= prescale_n;
         wrap_q     <= wrap_q_n;
         wrap       <= wrap_n;
      end
   end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Testbench for counter_run_ctrl: table of per-cycle vectors with hand-derived
// expected count and status, checked through an expectation queue.
module tb_counter_run_ctrl;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_PAUSE = 2'b10;
   localparam logic [1:0] OP_LOAD  = 2'b11;

   // Status flags packed as {busy, paused, done, wrap, cmd_ready}
   localparam logic [4:0] F_I = 5'b00001;
   localparam logic [4:0] F_R = 5'b10001;
   localparam logic [4:0] F_P = 5'b11001;
   localparam logic [4:0] F_D = 5'b00100;
   localparam logic [4:0] F_W = 5'b10011;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_data = 8'h00;
   logic [7:0] limit = 8'h00;
   logic [3:0] prescale = 4'h0;
   logic       wrap_en = 1'b0;
   logic [7:0] count;
   logic       busy, paused, done, wrap;

   counter_run_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .limit(limit), .prescale(prescale),
      .wrap_en(wrap_en), .count(count), .busy(busy), .paused(paused),
      .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       v;
      logic [1:0] op;
      logic [7:0] d;
      logic [7:0] lim;
      logic [3:0] pre;
      logic       wen;
      logic [7:0] ecnt;
      logic [4:0] eflg;
   } vec_t;

   typedef struct {
      int         idx;
      logic [7:0] ecnt;
      logic [4:0] eflg;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [7:0] cur_lim = 8'h00;
   logic [3:0] cur_pre = 4'h0;
   logic       cur_wen = 1'b0;

   function automatic void cfg(input logic [7:0] l, input logic [3:0] p, input logic w);
      cur_lim = l;
      cur_pre = p;
      cur_wen = w;
   endfunction

   function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                               input logic [7:0] d, input logic [7:0] ecnt,
                               input logic [4:0] ef);
      vec_t t;
      t.rst = r; t.v = v; t.op = op; t.d = d;
      t.lim = cur_lim; t.pre = cur_pre; t.wen = cur_wen;
      t.ecnt = ecnt; t.eflg = ef;
      return t;
   endfunction

   function automatic void nop(input logic [7:0] ecnt, input logic [4:0] ef);
      vecs.push_back(mk(1'b0, 1'b0, OP_START, 8'h00, ecnt, ef));
   endfunction

   function automatic void cmd(input logic [1:0] op, input logic [7:0] d,
                               input logic [7:0] ecnt, input logic [4:0] ef);
      vecs.push_back(mk(1'b0, 1'b1, op, d, ecnt, ef));
   endfunction

   // Drive one cycle of stimulus, queue its expectation, check after the edge
   task automatic apply(input vec_t t, input int idx);
      exp_t e;
      @(negedge clk);
      reset     = t.rst;
      cmd_valid = t.v;
      cmd_op    = t.op;
      cmd_data  = t.d;
      limit     = t.lim;
      prescale  = t.pre;
      wrap_en   = t.wen;
      e.idx = idx; e.ecnt = t.ecnt; e.eflg = t.eflg;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL vec%0d: no expectation queued", idx);
      end else begin
         e = exp_q.pop_front();
         if ({count, busy, paused, done, wrap, cmd_ready} !== {e.ecnt, e.eflg}) begin
            n_err++;
            $display("FAIL vec%0d: got count=%h flags(b,p,d,w,r)=%b, want count=%h flags=%b",
                     e.idx, count, {busy, paused, done, wrap, cmd_ready}, e.ecnt, e.eflg);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      vecs.push_back(mk(1'b1, 1'b0, OP_START, 8'h00, 8'h00, F_I));
      vecs.push_back(mk(1'b1, 1'b0, OP_START, 8'h00, 8'h00, F_I));
      nop(8'h00, F_I);

      // limit 5, no wrap, prescale 0
      cfg(8'd5, 4'd0, 1'b0);
      cmd(OP_START, 8'h00, 8'd0, F_R);
      for (int i = 1; i <= 5; i++) nop(8'(i), F_R);
      nop(8'd5, F_D);
      nop(8'd5, F_I);
      nop(8'd5, F_I);

      // limit 3, wrap; input changes after START must be ignored
      cfg(8'd3, 4'd0, 1'b1);
      cmd(OP_START, 8'h00, 8'd0, F_R);
      cfg(8'd1, 4'd3, 1'b0);
      nop(8'd1, F_R); nop(8'd2, F_R); nop(8'd3, F_R); nop(8'd0, F_W);
      nop(8'd1, F_R); nop(8'd2, F_R); nop(8'd3, F_R); nop(8'd0, F_W);
      nop(8'd1, F_R);
      cmd(OP_STOP, 8'h00, 8'd1, F_I);

      // limit 4, prescale 2: one increment every third cycle
      cfg(8'd4, 4'd2, 1'b0);
      cmd(OP_START, 8'h00, 8'd0, F_R);
      for (int k = 0; k < 14; k++) nop(8'((k + 1) / 3), F_R);
      nop(8'd4, F_D);
      nop(8'd4, F_I);

      // pause/resume with prescaler continuity (prescale 1)
      cfg(8'd9, 4'd1, 1'b0);
      cmd(OP_START, 8'h00, 8'd0, F_R);
      nop(8'd0, F_R); nop(8'd1, F_R); nop(8'd1, F_R); nop(8'd2, F_R); nop(8'd2, F_R);
      cmd(OP_PAUSE, 8'h00, 8'd2, F_P);
      for (int i = 0; i < 10; i++) nop(8'd2, F_P);
      cmd(OP_PAUSE, 8'h00, 8'd2, F_R);
      nop(8'd3, F_R); nop(8'd3, F_R); nop(8'd4, F_R);
      cmd(OP_STOP, 8'h00, 8'd4, F_I);

      // limit 0 in non-wrap mode finishes on the first tick
      cfg(8'd0, 4'd0, 1'b0);
      cmd(OP_START, 8'h00, 8'd0, F_R);
      nop(8'd0, F_D);
      nop(8'd0, F_I);

      // LOAD above limit: natural rollover without a wrap pulse
      cfg(8'd2, 4'd0, 1'b0);
      cmd(OP_START, 8'h00, 8'd0, F_R);
      cmd(OP_LOAD, 8'hFE, 8'hFE, F_R);
      nop(8'hFF, F_R); nop(8'h00, F_R); nop(8'h01, F_R); nop(8'h02, F_R);
      nop(8'h02, F_D);
      nop(8'h02, F_I);

      // LOAD on a tick cycle discards the tick
      cfg(8'hF2, 4'd0, 1'b0);
      cmd(OP_START, 8'h00, 8'h00, F_R);
      nop(8'h01, F_R);
      cmd(OP_LOAD, 8'hF0, 8'hF0, F_R);
      nop(8'hF1, F_R); nop(8'hF2, F_R);
      nop(8'hF2, F_D);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // START held through DONE: refused there, accepted the next cycle
      apply(mk(1'b0, 1'b1, OP_START, 8'h00, 8'hF2, F_I), 1000);
      apply(mk(1'b0, 1'b1, OP_START, 8'h00, 8'h00, F_R), 1001);
      for (int i = 1; i <= 7; i++) apply(mk(1'b0, 1'b0, OP_START, 8'h00, 8'(i), F_R), 1001 + i);

      // Reset mid-run at count 7 wins over a concurrent START
      apply(mk(1'b1, 1'b1, OP_START, 8'h00, 8'h00, F_I), 1010);
      apply(mk(1'b0, 1'b1, OP_STOP,  8'h00, 8'h00, F_I), 1011);
      apply(mk(1'b0, 1'b1, OP_LOAD,  8'h07, 8'h07, F_I), 1012);
      apply(mk(1'b0, 1'b1, OP_STOP,  8'h00, 8'h07, F_I), 1013);
      apply(mk(1'b0, 1'b1, OP_PAUSE, 8'h00, 8'h07, F_I), 1014);

      // Restart from RUN clears the count
      apply(mk(1'b0, 1'b1, OP_START, 8'h00, 8'h00, F_R), 1015);
      apply(mk(1'b0, 1'b0, OP_START, 8'h00, 8'h01, F_R), 1016);
      apply(mk(1'b0, 1'b0, OP_START, 8'h00, 8'h02, F_R), 1017);
      apply(mk(1'b0, 1'b1, OP_START, 8'h00, 8'h00, F_R), 1018);
      apply(mk(1'b0, 1'b0, OP_START, 8'h00, 8'h01, F_R), 1019);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
